// File: rtl/useq_pkg.sv
// Shared op-code definitions for the microsequencer and its return stack.
package useq_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_INC     = 3'd0;
  localparam logic [OP_W-1:0] OP_JUMP    = 3'd1;
  localparam logic [OP_W-1:0] OP_BRANCH  = 3'd2;
  localparam logic [OP_W-1:0] OP_WAIT    = 3'd3;
  localparam logic [OP_W-1:0] OP_CALL    = 3'd4;
  localparam logic [OP_W-1:0] OP_RETURN  = 3'd5;
  localparam logic [OP_W-1:0] OP_DECODE  = 3'd6;
  localparam logic [OP_W-1:0] OP_RESTART = 3'd7;

endpackage

// File: rtl/useq_stack.sv
// LIFO microsubroutine return stack; push/pop/clear with full/empty flags.
// Push on full and pop on empty are ignored here; the caller flags the error.
module useq_stack #(
  parameter int unsigned W     = 5,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] cnt;
  logic [IDX_W-1:0] top_idx;
  logic [W-1:0]     mem [DEPTH];

  assign full    = (cnt == PTR_W'(DEPTH));
  assign empty   = (cnt == {PTR_W{1'b0}});
  assign top_idx = cnt[IDX_W-1:0] - IDX_W'(1);
  assign top     = mem[top_idx];

  // Occupancy pointer; clear wins over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= {PTR_W{1'b0}};
    end else if (clear) begin
      cnt <= {PTR_W{1'b0}};
    end else if (push && !full) begin
      cnt <= cnt + PTR_W'(1);
    end else if (pop && !empty) begin
      cnt <= cnt - PTR_W'(1);
    end
  end

  // Entry storage needs no reset: the pointer alone defines what is valid.
  always_ff @(posedge clk) begin
    if (push && !full && !clear) begin
      mem[cnt[IDX_W-1:0]] <= din;
    end
  end

endmodule

// File: rtl/microsequencer.sv
// Next control-store address sequencer: mux, state register, incrementer, stall/error.
// Define USEQ_STACK_EN to build the return stack; otherwise CALL=JUMP, RETURN=RESTART.
module microsequencer
  import useq_pkg::*;
#(
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned RESET_ADDR  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OP_W-1:0]   op,
  input  logic [ADDR_W-1:0] target,
  input  logic [ADDR_W-1:0] decode_addr,
  input  logic              cond,
  input  logic              inv,
  input  logic              moc,
  output logic [ADDR_W-1:0] state_addr,
  output logic [ADDR_W-1:0] inc_addr,
  output logic              stall,
  output logic              stack_err
);

  localparam logic [ADDR_W-1:0] RST_A = ADDR_W'(RESET_ADDR);

  logic [ADDR_W-1:0] next_addr;

`ifdef USEQ_STACK_EN
  logic              push;
  logic              pop;
  logic              clear;
  logic              err_set;
  logic              full;
  logic              empty;
  logic [ADDR_W-1:0] top;

  useq_stack #(
    .W     (ADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .clear (clear),
    .din   (inc_addr),
    .top   (top),
    .full  (full),
    .empty (empty)
  );
`endif

  assign inc_addr = state_addr + ADDR_W'(1);
  // Reset must drop stall immediately, not just at the next edge.
  assign stall    = (op == OP_WAIT) && !moc && !reset;

  // Next-address selection and stack control.
  always_comb begin
    next_addr = inc_addr;
`ifdef USEQ_STACK_EN
    push    = 1'b0;
    pop     = 1'b0;
    clear   = 1'b0;
    err_set = 1'b0;
`endif
    case (op)
      OP_INC:    next_addr = inc_addr;
      OP_JUMP:   next_addr = target;
      OP_BRANCH: next_addr = (cond ^ inv) ? target : inc_addr;
      OP_WAIT:   next_addr = moc ? inc_addr : state_addr;
      OP_CALL: begin
        next_addr = target;
`ifdef USEQ_STACK_EN
        push    = 1'b1;
        err_set = full;
`endif
      end
      OP_RETURN: begin
`ifdef USEQ_STACK_EN
        pop = 1'b1;
        if (empty) begin
          next_addr = RST_A;
          err_set   = 1'b1;
        end else begin
          next_addr = top;
        end
`else
        next_addr = RST_A;
`endif
      end
      OP_DECODE: next_addr = decode_addr;
      OP_RESTART: begin
        next_addr = RST_A;
`ifdef USEQ_STACK_EN
        clear = 1'b1;
`endif
      end
      default: next_addr = inc_addr;
    endcase
  end

  // Current control-store address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_addr <= RST_A;
    end else begin
      state_addr <= next_addr;
    end
  end

`ifdef USEQ_STACK_EN
  // Sticky stack error, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stack_err <= 1'b0;
    end else if (err_set) begin
      stack_err <= 1'b1;
    end
  end
`else
  assign stack_err = 1'b0;
`endif

endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench for microsequencer: directed steps then random ops vs. a queue-based model.
module tb_microsequencer;

  localparam int AW    = 5;
  localparam int DEPTH = 4;
  localparam int MODN  = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    op;
  logic [AW-1:0] target;
  logic [AW-1:0] decode_addr;
  logic          cond;
  logic          inv;
  logic          moc;
  logic [AW-1:0] state_addr;
  logic [AW-1:0] inc_addr;
  logic          stall;
  logic          stack_err;

  int total = 0;
  int bad   = 0;

  int m_st;
  bit m_err;
  int m_stk[$];

  microsequencer #(
    .ADDR_W      (AW),
    .STACK_DEPTH (DEPTH),
    .RESET_ADDR  (0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .target      (target),
    .decode_addr (decode_addr),
    .cond        (cond),
    .inv         (inv),
    .moc         (moc),
    .state_addr  (state_addr),
    .inc_addr    (inc_addr),
    .stall       (stall),
    .stack_err   (stack_err)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st  = 0;
    m_err = 1'b0;
    m_stk.delete();
  endtask

  // Architectural effect of one op on the model.
  task automatic model_step();
    int nxt;
    nxt = (m_st + 1) % MODN;
    case (op)
      3'd0: m_st = nxt;
      3'd1: m_st = int'(target);
      3'd2: m_st = (cond != inv) ? int'(target) : nxt;
      3'd3: m_st = moc ? nxt : m_st;
      3'd4: begin
`ifdef USEQ_STACK_EN
        if (m_stk.size() == DEPTH) m_err = 1'b1;
        else m_stk.push_back(nxt);
`endif
        m_st = int'(target);
      end
      3'd5: begin
`ifdef USEQ_STACK_EN
        if (m_stk.size() == 0) begin
          m_st  = 0;
          m_err = 1'b1;
        end else begin
          m_st = m_stk.pop_back();
        end
`else
        m_st = 0;
`endif
      end
      3'd6: m_st = int'(decode_addr);
      3'd7: begin
        m_st = 0;
        m_stk.delete();
      end
      default: m_st = nxt;
    endcase
  endtask

  task automatic step(string tag, logic [2:0] o, logic [AW-1:0] t, logic [AW-1:0] d,
                      logic c, logic i, logic m);
    op = o; target = t; decode_addr = d; cond = c; inv = i; moc = m;
    #1;
    chk({tag, ".stall"}, 32'(stall), 32'((o == 3'd3) && !m));
    chk({tag, ".inc"}, 32'(inc_addr), 32'((m_st + 1) % MODN));
    model_step();
    @(posedge clk);
    #1;
    chk({tag, ".addr"}, 32'(state_addr), 32'(m_st));
    chk({tag, ".err"}, 32'(stack_err), 32'(m_err));
  endtask

  initial begin
    reset = 1'b1;
    op = 3'd3; target = '0; decode_addr = '0; cond = 1'b0; inv = 1'b0; moc = 1'b0;
    model_reset();
    #12;
    chk("rst.addr", 32'(state_addr), 32'd0);
    chk("rst.err", 32'(stack_err), 32'd0);
    chk("rst.stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Increment through the full address space and wrap to 0.
    for (int k = 0; k < 32; k++) step("inc", 3'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("wrap.addr", 32'(state_addr), 32'd0);

    step("jmp4", 3'd1, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0);
    step("br_taken", 3'd2, 5'd20, 5'd0, 1'b1, 1'b0, 1'b0);
    chk("br_taken.abs", 32'(state_addr), 32'd20);
    step("jmp4b", 3'd1, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0);
    step("br_inv", 3'd2, 5'd20, 5'd0, 1'b1, 1'b1, 1'b0);
    chk("br_inv.abs", 32'(state_addr), 32'd5);

    for (int k = 0; k < 3; k++) step("wait_hold", 3'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step("wait_go", 3'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    chk("wait_go.abs", 32'(state_addr), 32'd6);

    step("jmp3", 3'd1, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);
    step("call10", 3'd4, 5'd10, 5'd0, 1'b0, 1'b0, 1'b0);
    step("ret", 3'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step("dec", 3'd6, 5'd0, 5'd17, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 5; k++) step("nest", 3'd4, 5'(11 + k), 5'd0, 1'b0, 1'b0, 1'b0);
    chk("nest5.abs", 32'(state_addr), 32'd15);
    step("restart", 3'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step("jmp7", 3'd1, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0);
    step("ret_empty", 3'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

    step("call9", 3'd4, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("call9.abs", 32'(state_addr), 32'd9);
    step("ret9", 3'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a WAIT.
    step("jmp13", 3'd1, 5'd13, 5'd0, 1'b0, 1'b0, 1'b0);
    step("call_pre", 3'd4, 5'd22, 5'd0, 1'b0, 1'b0, 1'b0);
    step("wait_pre", 3'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("arst.addr", 32'(state_addr), 32'd0);
    chk("arst.stall", 32'(stall), 32'd0);
    chk("arst.err", 32'(stack_err), 32'd0);
    reset = 1'b0;
    step("post_rst", 3'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    step("post_ret", 3'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

    // Random op stream against the model.
    for (int k = 0; k < 600; k++) begin
      step("rnd", 3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
